divider_ctrl: RTL and testbench

Sequencing and arbitration wrapper around the combinational array divider. Two requesters share one divider instance through valid/ready handshakes. A round-robin arbiter picks one request, and the controller registers its operands and holds them for a fixed number of settle cycles, because the array is a multicycle path. It then registers the quotient and presents it on a response channel tagged with the requester ID.

---
 rtl/divider_pkg.sv | 25 ++
 rtl/divider_ctrl_array.sv | 37 +++
 rtl/divider_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_divider_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and defaults for the divider controller slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, default widths, settle-counter width helper.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int DEVIDENT_LENGTH_DEF = 6;
  localparam int DIVISOR_LENGTH_DEF  = 3;
  localparam int SETTLE_CYCLES_DEF   = 2;

  // One extra bit so the counter can always hold SETTLE_CYCLES-1,
  // including the SETTLE_CYCLES==1 corner where clog2 returns 0.
  function automatic int cnt_width(input int settle);
    return $clog2(settle) + 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(SETTLE_CYCLES_DEF);

endpackage

// File: rtl/divider_ctrl_array.sv
// Combinational restoring array divider: quotient = dividend / divisor.
// Latency: purely combinational; callers treat it as a multicycle path.
// Backpressure: none (no state).
// Ports:
//   dividend_i  DEVIDENT_LENGTH-bit unsigned dividend
//   divisor_i   DIVISOR_LENGTH-bit unsigned divisor
//   quotient_o  DEVIDENT_LENGTH-bit unsigned quotient
module divider_ctrl_array
  import divider_pkg::*;
#(
  parameter int DEVIDENT_LENGTH = DEVIDENT_LENGTH_DEF,
  parameter int DIVISOR_LENGTH  = DIVISOR_LENGTH_DEF
) (
  input  logic [DEVIDENT_LENGTH-1:0] dividend_i,
  input  logic [DIVISOR_LENGTH-1:0]  divisor_i,
  output logic [DEVIDENT_LENGTH-1:0] quotient_o
);

  // Partial remainder carried from row to row. After a successful
  // subtract it is always below the divisor, so DIVISOR_LENGTH bits
  // plus one for the shifted-in dividend bit are enough.
  logic [DIVISOR_LENGTH:0] rem;

  always_comb begin
    rem        = '0;
    quotient_o = '0;
    for (int i = DEVIDENT_LENGTH - 1; i >= 0; i--) begin
      rem = {rem[DIVISOR_LENGTH-1:0], dividend_i[i]};
      // A zero divisor makes every row succeed, giving an all-ones quotient.
      if (rem >= {1'b0, divisor_i}) begin
        rem           = rem - {1'b0, divisor_i};
        quotient_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/divider_ctrl.sv
// Two-requester round-robin front end that sequences one shared array divider.
// Latency: result valid SETTLE_CYCLES cycles after accept (1 cycle for a zero
//          divisor when DIVIDER_CTRL_DIV0_CHECK_EN is defined).
// Backpressure: result held in DONE until rsp_ready; no request accepted
//               until the response handshake completes.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   reqN_valid/ready/a/d (N=0,1)    request channels (dividend a, divisor d)
//   rsp_valid/ready                 response handshake
//   rsp_quotient, rsp_id, rsp_div0  registered result, requester tag, zero-divisor flag
//   busy                            high whenever an operation is in flight
// Optional feature macro: DIVIDER_CTRL_DIV0_CHECK_EN (zero-divisor short cut).
module divider_ctrl
  import divider_pkg::*;
#(
  parameter int DEVIDENT_LENGTH = DEVIDENT_LENGTH_DEF,
  parameter int DIVISOR_LENGTH  = DIVISOR_LENGTH_DEF,
  parameter int SETTLE_CYCLES   = SETTLE_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [DEVIDENT_LENGTH-1:0] req0_a,
  input  logic [DIVISOR_LENGTH-1:0]  req0_d,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [DEVIDENT_LENGTH-1:0] req1_a,
  input  logic [DIVISOR_LENGTH-1:0]  req1_d,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DEVIDENT_LENGTH-1:0] rsp_quotient,
  output logic                       rsp_id,
  output logic                       rsp_div0,
  output logic                       busy
);

  localparam int               CNT_W    = cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [DEVIDENT_LENGTH-1:0] opa_q, opa_d;
  logic [DIVISOR_LENGTH-1:0]  opd_q, opd_d;
  logic                       id_q, id_d;
  logic                       last_grant_q, last_grant_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [DEVIDENT_LENGTH-1:0] rsp_quot_q, rsp_quot_d;
  logic                       rsp_id_q, rsp_id_d;
`ifdef DIVIDER_CTRL_DIV0_CHECK_EN
  logic                       rsp_div0_q, rsp_div0_d;
`endif

  logic                       grant0, grant1, accept;
  logic [DEVIDENT_LENGTH-1:0] sel_a;
  logic [DIVISOR_LENGTH-1:0]  sel_d;
  logic [DEVIDENT_LENGTH-1:0] div_quot;

  // Round robin: on a tie the requester that did not win last time goes.
  // The two grants are mutually exclusive by construction.
  assign grant0 = req0_valid & (~req1_valid | last_grant_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

  // Gated by rst_n so nothing can handshake while reset is being applied.
  assign req0_ready = rst_n & (state_q == IDLE) & grant0;
  assign req1_ready = rst_n & (state_q == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;

  assign sel_a = grant1 ? req1_a : req0_a;
  assign sel_d = grant1 ? req1_d : req0_d;

  // Divider sees only the operand registers, which hold still for the whole
  // SETTLE window; this is what makes the multicycle constraint legal.
  divider_ctrl_array #(
    .DEVIDENT_LENGTH (DEVIDENT_LENGTH),
    .DIVISOR_LENGTH  (DIVISOR_LENGTH)
  ) u_array (
    .dividend_i (opa_q),
    .divisor_i  (opd_q),
    .quotient_o (div_quot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      opa_q        <= '0;
      opd_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_quot_q   <= '0;
      rsp_id_q     <= 1'b0;
`ifdef DIVIDER_CTRL_DIV0_CHECK_EN
      rsp_div0_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      opa_q        <= opa_d;
      opd_q        <= opd_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_quot_q   <= rsp_quot_d;
      rsp_id_q     <= rsp_id_d;
`ifdef DIVIDER_CTRL_DIV0_CHECK_EN
      rsp_div0_q   <= rsp_div0_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    opa_d        = opa_q;
    opd_d        = opd_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_quot_d   = rsp_quot_q;
    rsp_id_d     = rsp_id_q;
`ifdef DIVIDER_CTRL_DIV0_CHECK_EN
    rsp_div0_d   = rsp_div0_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          opa_d        = sel_a;
          opd_d        = sel_d;
          id_d         = grant1;
          last_grant_d = grant1;
          cnt_d        = CNT_LOAD;
          state_d      = SETTLE;
`ifdef DIVIDER_CTRL_DIV0_CHECK_EN
          // Zero divisor needs no array result, so answer immediately.
          if (sel_d == '0) begin
            rsp_quot_d  = '1;
            rsp_id_d    = grant1;
            rsp_div0_d  = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = DONE;
          end
`endif
        end
      end

      SETTLE: begin
        if (cnt_q == '0) begin
          rsp_quot_d  = div_quot;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
`ifdef DIVIDER_CTRL_DIV0_CHECK_EN
          rsp_div0_d  = 1'b0;
`endif
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_quotient = rsp_quot_q;
  assign rsp_id       = rsp_id_q;
  assign busy         = (state_q != IDLE);
`ifdef DIVIDER_CTRL_DIV0_CHECK_EN
  assign rsp_div0     = rsp_div0_q;
`else
  assign rsp_div0     = 1'b0;
`endif

endmodule

// File: tb/tb_divider_ctrl.sv
// Scoreboard bench for divider_ctrl: accepts are modelled as a FIFO of
// expected results; a negedge monitor compares every presented response.
// Reference quotient is plain integer division.
module tb_divider_ctrl;

  localparam int AW = 6;
  localparam int DW = 3;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_a, req1_a;
  logic [DW-1:0] req0_d, req1_d;
  logic          rsp_valid, rsp_ready;
  logic [AW-1:0] rsp_quotient;
  logic          rsp_id, rsp_div0, busy;

  always #5 clk = ~clk;

  divider_ctrl #(
    .DEVIDENT_LENGTH (AW),
    .DIVISOR_LENGTH  (DW),
    .SETTLE_CYCLES   (SC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_a       (req0_a),
    .req0_d       (req0_d),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_a       (req1_a),
    .req1_d       (req1_d),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_quotient (rsp_quotient),
    .rsp_id       (rsp_id),
    .rsp_div0     (rsp_div0),
    .busy         (busy)
  );

  typedef struct {
    logic [AW-1:0] q;
    bit            qk;      // quotient defined by the reference
    bit            id;
    bit            dz;
    int            acc_ns;  // monitor sample index of the accept
    int            lat;     // samples from accept to first valid
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   ns = 0;
  int   rdy_mode = 0;  // 0: ready high, 1: ready low, 2: random

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model(input bit id, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d, input int now);
    exp_t e;
    e.id     = id;
    e.acc_ns = now;
    if (d == 0) begin
`ifdef DIVIDER_CTRL_DIV0_CHECK_EN
      e.q   = AW'((1 << AW) - 1);
      e.qk  = 1'b1;
      e.dz  = 1'b1;
      e.lat = 1;
`else
      e.q   = '0;
      e.qk  = 1'b0;
      e.dz  = 1'b0;
      e.lat = SC + 1;
`endif
    end else begin
      e.q   = AW'(int'(a) / int'(d));
      e.qk  = 1'b1;
      e.dz  = 1'b0;
      e.lat = SC + 1;
    end
    return e;
  endfunction

  // Monitor / scoreboard
  initial begin
    exp_t e;
    bit   w;
    bit   prev_win = 1'b1;
    bit   prev_vld = 1'b0;
    bit   prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      ns++;
      if (!rst_n) begin
        expq.delete();
        prev_win = 1'b1;
        prev_vld = 1'b0;
        prev_rdy = 1'b0;
      end else begin
        chk("both_ready", 64'(req0_ready & req1_ready), 64'd0);
        if (expq.size() != 0) begin
          chk("ready_while_busy", 64'(req0_ready | req1_ready), 64'd0);
          chk("busy_inflight", 64'(busy), 64'd1);
        end else begin
          chk("busy_idle", 64'(busy), 64'd0);
        end

        if (prev_vld && !prev_rdy)
          chk("rsp_valid_held", 64'(rsp_valid), 64'd1);

        if (rsp_valid) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: rsp_valid=1 id=%0d q=%0d, expected no response", rsp_id, rsp_quotient);
          end else begin
            e = expq[0];
            if (!prev_vld) chk("latency", 64'(ns - e.acc_ns), 64'(e.lat));
            chk("rsp_id", 64'(rsp_id), 64'(e.id));
            chk("rsp_div0", 64'(rsp_div0), 64'(e.dz));
            if (e.qk) chk("rsp_quotient", 64'(rsp_quotient), 64'(e.q));
            if (rsp_ready) void'(expq.pop_front());
          end
        end

        if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
          w = req1_ready;
          if (req0_valid && req1_valid) chk("arb_winner", 64'(w), 64'(!prev_win));
          expq.push_back(model(w, w ? req1_a : req0_a, w ? req1_d : req0_d, ns));
          prev_win = w;
        end

        prev_vld = rsp_valid;
        prev_rdy = rsp_ready;
      end
    end
  end

  // Response-side ready driver
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0)      rsp_ready = 1'b1;
      else if (rdy_mode == 1) rsp_ready = 1'b0;
      else                    rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input bit id, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n  = 0;
    bit ok = 1'b0;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_d = d; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_d = d; end
    while (!ok && n < 200) begin
      @(negedge clk);
      n++;
      ok = id ? req1_ready : req0_ready;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: requester %0d not accepted after %0d cycles, expected accept", id, n);
    end
    @(posedge clk);
    #1;
    if (id) req1_valid = 1'b0;
    else    req0_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(expq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rsp_valid"},    64'(rsp_valid),    64'd0);
    chk({tag, "_rsp_quotient"}, 64'(rsp_quotient), 64'd0);
    chk({tag, "_rsp_id"},       64'(rsp_id),       64'd0);
    chk({tag, "_rsp_div0"},     64'(rsp_div0),     64'd0);
    chk({tag, "_busy"},         64'(busy),         64'd0);
    chk({tag, "_req0_ready"},   64'(req0_ready),   64'd0);
    chk({tag, "_req1_ready"},   64'(req1_ready),   64'd0);
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    req1_valid = 1'b0;
    req1_a     = '0;
    req1_d     = '0;
    // Valid already high during reset: ready must stay low until release.
    req0_valid = 1'b1;
    req0_a     = AW'(45);
    req0_d     = DW'(5);
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    rst_n = 1'b1;

    // Single request 45/5
    issue(1'b0, AW'(45), DW'(5));
    drain();

    // Ties from a fresh reset: req0 first, then req1, then req0 again
    pulse_reset("rst2");
    fork
      issue(1'b0, AW'(20), DW'(3));
      issue(1'b1, AW'(63), DW'(7));
    join
    drain();
    fork
      issue(1'b0, AW'(40), DW'(6));
      issue(1'b1, AW'(33), DW'(4));
    join
    drain();

    // Backpressure on 63/1 while req1 waits
    rdy_mode = 1;
    issue(1'b0, AW'(63), DW'(1));
    fork
      begin
        repeat (8) @(posedge clk);
        rdy_mode = 0;
      end
      issue(1'b1, AW'(10), DW'(2));
    join
    drain();

    // Zero divisor
    issue(1'b0, AW'(17), DW'(0));
    drain();

    // Reset while in SETTLE: in-flight result must vanish
    issue(1'b1, AW'(30), DW'(4));
    pulse_reset("mid");
    repeat (6) @(posedge clk);
    #1;
    issue(1'b0, AW'(50), DW'(7));
    drain();

    // Full operand sweep (nonzero divisor) under contention and random ready
    rdy_mode = 2;
    for (int i = 0; i < 448; i += 2) begin
      automatic int a0 = i % 64;
      automatic int d0 = i / 64 + 1;
      automatic int a1 = (i + 1) % 64;
      automatic int d1 = (i + 1) / 64 + 1;
      fork
        issue(1'b0, AW'(a0), DW'(d0));
        issue(1'b1, AW'(a1), DW'(d1));
      join
    end
    drain();

    // Random operands (zero divisor allowed) with staggered arrivals
    for (int k = 0; k < 60; k++) begin
      automatic logic [AW-1:0] ra0 = AW'($urandom_range(0, 63));
      automatic logic [AW-1:0] ra1 = AW'($urandom_range(0, 63));
      automatic logic [DW-1:0] rd0 = DW'($urandom_range(0, 7));
      automatic logic [DW-1:0] rd1 = DW'($urandom_range(0, 7));
      automatic int            dl0 = $urandom_range(0, 3);
      automatic int            dl1 = $urandom_range(0, 3);
      fork
        begin
          repeat (dl0) @(posedge clk);
          #1;
          issue(1'b0, ra0, rd0);
        end
        begin
          repeat (dl1) @(posedge clk);
          #1;
          issue(1'b1, ra1, rd1);
        end
      join
    end
    rdy_mode = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
